// File: rtl/count_register_write.sv
// 8254 counter write path: assembles CPU data bytes into the 16-bit count register
// according to the programmed RW mode and flags completed counts to the counting element.
module count_register_write (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  databus,
  input  logic        write,
  input  logic        control_word_write,
  input  logic [1:0]  rw_mode,
  input  logic        load_ack,
  output logic [15:0] count_register,
  output logic        load,
  output logic        null_count,
  output logic        waiting_msb,
  output logic        ol_unlatch
);

  localparam logic [1:0] RW_LATCH = 2'b00;
  localparam logic [1:0] RW_LSB   = 2'b01;
  localparam logic [1:0] RW_MSB   = 2'b10;
  localparam logic [1:0] RW_BOTH  = 2'b11;

  logic [1:0]  r_mode;
  logic        r_byte_ptr;
  logic [7:0]  r_lsb_hold;

  logic [1:0]  w_mode_nxt;
  logic        w_byte_ptr_nxt;
  logic [7:0]  w_lsb_hold_nxt;
  logic [15:0] w_count_nxt;
  logic        w_load_nxt;
  logic        w_null_nxt;
  logic        w_waiting_nxt;
  logic        w_unlatch_nxt;
  logic        w_count_set;
  logic        w_program;

  assign w_program = control_word_write && (rw_mode != RW_LATCH);

  always_comb begin
    w_mode_nxt     = r_mode;
    w_byte_ptr_nxt = r_byte_ptr;
    w_lsb_hold_nxt = r_lsb_hold;
    w_count_nxt    = count_register;
    w_load_nxt     = 1'b0;
    w_waiting_nxt  = waiting_msb;
    w_unlatch_nxt  = 1'b0;
    w_count_set    = 1'b0;

    if (w_program) begin
      w_mode_nxt     = rw_mode;
      w_byte_ptr_nxt = 1'b0;
      w_waiting_nxt  = 1'b0;
      w_unlatch_nxt  = 1'b1;
      w_count_set    = 1'b1;
    end else if (write && !control_word_write) begin
      // A control word in the same cycle (even a latch command) drops the data byte.
      case (r_mode)
        RW_LSB: begin
          w_count_nxt = {8'h00, databus};
          w_load_nxt  = 1'b1;
          w_count_set = 1'b1;
        end
        RW_MSB: begin
          w_count_nxt = {databus, 8'h00};
          w_load_nxt  = 1'b1;
          w_count_set = 1'b1;
        end
        RW_BOTH: begin
          if (!r_byte_ptr) begin
            w_lsb_hold_nxt = databus;
            w_byte_ptr_nxt = 1'b1;
            w_waiting_nxt  = 1'b1;
          end else begin
            w_count_nxt    = {databus, r_lsb_hold};
            w_byte_ptr_nxt = 1'b0;
            w_waiting_nxt  = 1'b0;
            w_load_nxt     = 1'b1;
            w_count_set    = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end

    // A freshly written count outranks an acknowledge of the previous one.
    if (w_count_set)
      w_null_nxt = 1'b1;
    else if (load_ack)
      w_null_nxt = 1'b0;
    else
      w_null_nxt = null_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode         <= RW_LATCH;
      r_byte_ptr     <= 1'b0;
      r_lsb_hold     <= 8'h00;
      count_register <= 16'h0000;
      load           <= 1'b0;
      null_count     <= 1'b0;
      waiting_msb    <= 1'b0;
      ol_unlatch     <= 1'b0;
    end else begin
      r_mode         <= w_mode_nxt;
      r_byte_ptr     <= w_byte_ptr_nxt;
      r_lsb_hold     <= w_lsb_hold_nxt;
      count_register <= w_count_nxt;
      load           <= w_load_nxt;
      null_count     <= w_null_nxt;
      waiting_msb    <= w_waiting_nxt;
      ol_unlatch     <= w_unlatch_nxt;
    end
  end

endmodule

// File: tb/tb_count_register_write.sv
// Scoreboard bench for count_register_write: a behavioural model pushes the expected
// outputs for each driven cycle, and they are popped and compared after the clock edge.
module tb_count_register_write;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  databus;
  logic        write;
  logic        control_word_write;
  logic [1:0]  rw_mode;
  logic        load_ack;
  logic [15:0] count_register;
  logic        load;
  logic        null_count;
  logic        waiting_msb;
  logic        ol_unlatch;

  always #5 clk = ~clk;

  count_register_write dut (
    .clk                (clk),
    .reset              (reset),
    .databus            (databus),
    .write              (write),
    .control_word_write (control_word_write),
    .rw_mode            (rw_mode),
    .load_ack           (load_ack),
    .count_register     (count_register),
    .load               (load),
    .null_count         (null_count),
    .waiting_msb        (waiting_msb),
    .ol_unlatch         (ol_unlatch)
  );

  typedef struct packed {
    logic [15:0] cr;
    logic        ld;
    logic        nc;
    logic        wm;
    logic        ul;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  // behavioural model of the counter write side
  logic [1:0]  m_mode;
  logic        m_ptr;
  logic [7:0]  m_lsb;
  logic [15:0] m_cr;
  logic        m_null;
  logic        m_wait;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic rst, input logic cw, input logic [1:0] rw,
                       input logic wr, input logic [7:0] d, input logic ack,
                       output exp_t e);
    logic ld, ul, fresh;
    ld = 1'b0; ul = 1'b0; fresh = 1'b0;
    if (rst) begin
      m_mode = 2'b00; m_ptr = 1'b0; m_lsb = 8'h00;
      m_cr = 16'h0000; m_null = 1'b0; m_wait = 1'b0;
    end else begin
      if (cw) begin
        if (rw != 2'b00) begin
          m_mode = rw; m_ptr = 1'b0; m_wait = 1'b0; ul = 1'b1; fresh = 1'b1;
        end
      end else if (wr) begin
        if (m_mode == 2'b01) begin
          m_cr = {8'h00, d}; ld = 1'b1; fresh = 1'b1;
        end else if (m_mode == 2'b10) begin
          m_cr = {d, 8'h00}; ld = 1'b1; fresh = 1'b1;
        end else if (m_mode == 2'b11 && !m_ptr) begin
          m_lsb = d; m_ptr = 1'b1; m_wait = 1'b1;
        end else if (m_mode == 2'b11) begin
          m_cr = {d, m_lsb}; m_ptr = 1'b0; m_wait = 1'b0; ld = 1'b1; fresh = 1'b1;
        end
      end
      if (fresh) m_null = 1'b1;
      else if (ack) m_null = 1'b0;
    end
    e.cr = m_cr; e.ld = ld; e.nc = m_null; e.wm = m_wait; e.ul = ul;
  endtask

  task automatic step(input logic rst, input logic cw, input logic [1:0] rw,
                      input logic wr, input logic [7:0] d, input logic ack);
    exp_t e;
    @(negedge clk);
    reset = rst; control_word_write = cw; rw_mode = rw;
    write = wr; databus = d; load_ack = ack;
    model(rst, cw, rw, wr, d, ack, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    chk("sb_depth", sb_q.size(), 1);
    e = sb_q.pop_front();
    chk("count_register", count_register, e.cr);
    chk("load", load, e.ld);
    chk("null_count", null_count, e.nc);
    chk("waiting_msb", waiting_msb, e.wm);
    chk("ol_unlatch", ol_unlatch, e.ul);
  endtask

  task automatic idle();                  step(0, 0, 2'b00, 0, 8'h00, 0); endtask
  task automatic cword(input logic [1:0] rw); step(0, 1, rw, 0, 8'h00, 0); endtask
  task automatic wbyte(input logic [7:0] d);  step(0, 0, 2'b00, 1, d, 0); endtask
  task automatic ackc();                  step(0, 0, 2'b00, 0, 8'h00, 1); endtask

  initial begin
    reset = 1'b1; control_word_write = 1'b0; rw_mode = 2'b00;
    write = 1'b0; databus = 8'h00; load_ack = 1'b0;
    m_mode = 2'b00; m_ptr = 1'b0; m_lsb = 8'h00;
    m_cr = 16'h0000; m_null = 1'b0; m_wait = 1'b0;

    step(1, 0, 2'b00, 0, 8'h00, 0);
    step(1, 0, 2'b00, 0, 8'h00, 0);
    chk("rst_cr", count_register, 16'h0000);
    chk("rst_null", null_count, 1'b0);

    // unprogrammed counter ignores data
    wbyte(8'h55);
    chk("unprog_cr", count_register, 16'h0000);
    chk("unprog_load", load, 1'b0);
    chk("unprog_null", null_count, 1'b0);

    // LSB then MSB
    cword(2'b11);
    chk("cw_unlatch", ol_unlatch, 1'b1);
    idle();
    chk("cw_unlatch_once", ol_unlatch, 1'b0);
    wbyte(8'h34);
    chk("lsb_wait", waiting_msb, 1'b1);
    chk("lsb_noload", load, 1'b0);
    wbyte(8'h12);
    chk("pair_cr", count_register, 16'h1234);
    chk("pair_load", load, 1'b1);
    chk("pair_null", null_count, 1'b1);
    idle();
    chk("pair_load_once", load, 1'b0);
    ackc();
    chk("ack_null", null_count, 1'b0);

    // LSB only / MSB only, back-to-back writes
    cword(2'b01);
    wbyte(8'hA5);
    chk("lsb_only_cr", count_register, 16'h00A5);
    wbyte(8'h3C);
    chk("b2b_load", load, 1'b1);
    cword(2'b10);
    wbyte(8'hA5);
    chk("msb_only_cr", count_register, 16'hA500);

    // reprogramming between LSB and MSB discards the held byte
    cword(2'b11);
    wbyte(8'h34);
    cword(2'b11);
    chk("reprog_keep_cr", count_register, 16'hA500);
    wbyte(8'h78);
    chk("reprog_noload", load, 1'b0);
    wbyte(8'h56);
    chk("reprog_cr", count_register, 16'h5678);

    // same-cycle control word and write
    step(0, 1, 2'b01, 1, 8'hFF, 0);
    chk("coll_cr", count_register, 16'h5678);
    chk("coll_load", load, 1'b0);

    // latch command mid-pair keeps the pointer
    cword(2'b11);
    wbyte(8'h11);
    step(0, 1, 2'b00, 0, 8'h00, 0);
    chk("latch_nounlatch", ol_unlatch, 1'b0);
    chk("latch_wait", waiting_msb, 1'b1);
    wbyte(8'h22);
    chk("latch_cr", count_register, 16'h2211);

    // completing write collides with acknowledge
    cword(2'b01);
    ackc();
    step(0, 0, 2'b00, 1, 8'h00, 1);
    chk("ack_coll_null", null_count, 1'b1);
    chk("zero_count", count_register, 16'h0000);

    // reset mid-pair, then unprogrammed again
    cword(2'b11);
    wbyte(8'hAB);
    step(1, 0, 2'b00, 1, 8'hCD, 1);
    chk("midrst_wait", waiting_msb, 1'b0);
    chk("midrst_null", null_count, 1'b0);
    wbyte(8'hCD);
    chk("midrst_ignored", count_register, 16'h0000);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0),
           2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
           8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
